// File: rtl/uart_pkg.sv
// Shared types and constants for the console UART transmitter.
// The line level per serializer state lives here so the top only registers it.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam logic [31:0] UART_TX_ADDR   = 32'hFFFF_FFFC;
  localparam logic [31:0] UART_STAT_ADDR = 32'hFFFF_FFF8;

  // Idle and stop bits are marks (high), the start bit is a space (low).
  function automatic logic lineLevel(input uart_state_t st, input logic dataBit);
    logic level;
    level = 1'b1;
    case (st)
      IDLE:    level = 1'b1;
      START:   level = 1'b0;
      DATA:    level = dataBit;
      STOP:    level = 1'b1;
      default: level = 1'b1;
    endcase
    return level;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO with occupancy count; a push is also taken while full
// when a pop happens in the same cycle, so a steady stream never stalls.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wrData,
  input  logic             pop,
  output logic [WIDTH-1:0] rdData,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] memReg [DEPTH];
  logic [PW-1:0]    wrPtrReg;
  logic [PW-1:0]    rdPtrReg;
  logic [CW-1:0]    countReg;
  logic             doPop;
  logic             doPush;

  assign full   = (countReg == CW'(DEPTH));
  assign empty  = (countReg == '0);
  assign count  = countReg;
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);

  // Head entry is visible combinationally so the serializer loads it on the pop edge.
  assign rdData = memReg[rdPtrReg];

  always_ff @(posedge clk) begin
    if (doPush) begin
      memReg[wrPtrReg] <= wrData;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      countReg <= '0;
    end else begin
      if (doPush) begin
        wrPtrReg <= wrPtrReg + PW'(1);
      end
      if (doPop) begin
        rdPtrReg <= rdPtrReg + PW'(1);
      end
      case ({doPush, doPop})
        2'b10:   countReg <= countReg + CW'(1);
        2'b01:   countReg <= countReg - CW'(1);
        default: countReg <= countReg;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter fed by console-port stores.
// Holds the serializer FSM, baud/bit counters, shift register and sticky overflow.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int CLKS_PER_BIT = 16,
  parameter  int FIFO_DEPTH   = 8,
  localparam int CW           = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wEn,
  input  logic [7:0]    data,
  input  logic          ovfClr,
  output logic          tx,
  output logic          busy,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          overflow
);

  localparam int BW = $clog2(CLKS_PER_BIT);

  uart_state_t   stateReg;
  logic [BW-1:0] baudReg;
  logic [2:0]    bitIdxReg;
  logic [7:0]    shiftReg;
  logic          txReg;
  logic          busyReg;
  logic          overflowReg;

  logic [7:0]    fifoRdData;
  logic          fifoFull;
  logic          fifoEmpty;
  logic [CW-1:0] fifoCount;
  logic          baudLast;
  logic          popThis;
  logic          dropped;

  assign baudLast = (baudReg == BW'(CLKS_PER_BIT - 1));
  // The last stop cycle may pop so consecutive frames run without an idle gap.
  assign popThis  = !fifoEmpty &&
                    ((stateReg == IDLE) || ((stateReg == STOP) && baudLast));
  assign dropped  = wEn && fifoFull && !popThis;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) txFifo (
    .clk    (clk),
    .rst    (rst),
    .push   (wEn),
    .wrData (data),
    .pop    (popThis),
    .rdData (fifoRdData),
    .full   (fifoFull),
    .empty  (fifoEmpty),
    .count  (fifoCount)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg    <= IDLE;
      baudReg     <= '0;
      bitIdxReg   <= '0;
      shiftReg    <= '0;
      txReg       <= 1'b1;
      busyReg     <= 1'b0;
      overflowReg <= 1'b0;
    end else begin
      // tx follows the state one cycle late, keeping the pin purely registered.
      txReg <= lineLevel(stateReg, shiftReg[0]);

      if (dropped) begin
        overflowReg <= 1'b1;
      end else if (ovfClr) begin
        overflowReg <= 1'b0;
      end

      case (stateReg)
        IDLE: begin
          if (popThis) begin
            shiftReg <= fifoRdData;
            baudReg  <= '0;
            stateReg <= START;
            busyReg  <= 1'b1;
          end
        end
        START: begin
          if (baudLast) begin
            baudReg   <= '0;
            bitIdxReg <= '0;
            stateReg  <= DATA;
          end else begin
            baudReg <= baudReg + BW'(1);
          end
        end
        DATA: begin
          if (baudLast) begin
            baudReg  <= '0;
            shiftReg <= shiftReg >> 1;
            if (bitIdxReg == 3'd7) begin
              stateReg <= STOP;
            end else begin
              bitIdxReg <= bitIdxReg + 3'd1;
            end
          end else begin
            baudReg <= baudReg + BW'(1);
          end
        end
        STOP: begin
          if (baudLast) begin
            baudReg <= '0;
            if (popThis) begin
              shiftReg <= fifoRdData;
              stateReg <= START;
            end else begin
              stateReg <= IDLE;
              busyReg  <= 1'b0;
            end
          end else begin
            baudReg <= baudReg + BW'(1);
          end
        end
        default: begin
          stateReg <= IDLE;
          busyReg  <= 1'b0;
        end
      endcase
    end
  end

  assign tx       = txReg;
  assign busy     = busyReg;
  assign full     = fifoFull;
  assign empty    = fifoEmpty;
  assign count    = fifoCount;
  assign overflow = overflowReg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed scenarios plus random traffic, every cycle
// compared against a frame-level model (byte queue + position within frame).
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       wEn;
  logic [7:0] data;
  logic       ovfClr;
  logic       tx;
  logic       busy;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       overflow;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wEn      (wEn),
    .data     (data),
    .ovfClr   (ovfClr),
    .tx       (tx),
    .busy     (busy),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  // Reference model: queued bytes, the byte on the wire and its cycle offset in the frame.
  logic [7:0] mq[$];
  bit         mInFrame;
  int         mPos;
  logic [7:0] mCur;
  bit         mOvf;
  bit         mTx;

  int vectors     = 0;
  int miscompares = 0;
  int busyCycles  = 0;

  // Line level at cycle pos of a frame: start bit, 8 data bits LSB first, stop bit.
  function automatic bit frameLevel(input logic [7:0] b, input int pos);
    int k;
    k = pos / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic w, input logic [7:0] d, input logic oc, input logic r);
    bit isFull;
    bit pop;
    bit dropped;
    wEn    = w;
    data   = d;
    ovfClr = oc;
    rst    = r;
    dropped = 1'b0;
    @(posedge clk);
    if (r) begin
      mq.delete();
      mInFrame = 1'b0;
      mPos     = 0;
      mOvf     = 1'b0;
      mTx      = 1'b1;
    end else begin
      mTx     = mInFrame ? frameLevel(mCur, mPos) : 1'b1;
      isFull  = (mq.size() == DEPTH);
      pop     = (mq.size() > 0) && (!mInFrame || mPos == FRAME - 1);
      dropped = w && isFull && !pop;
      if (pop) begin
        mCur     = mq.pop_front();
        mInFrame = 1'b1;
        mPos     = 0;
      end else if (mInFrame) begin
        if (mPos == FRAME - 1) mInFrame = 1'b0;
        else mPos++;
      end
      if (w && !dropped) mq.push_back(d);
      if (dropped) mOvf = 1'b1;
      else if (oc) mOvf = 1'b0;
    end
    #1;
    if (w && !r) $display("push %02h %s count=%0d", d, dropped ? "dropped" : "accepted", count);
    chk("tx", 32'(tx), 32'(mTx));
    chk("busy", 32'(busy), 32'(mInFrame));
    chk("count", 32'(count), 32'(mq.size()));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("overflow", 32'(overflow), 32'(mOvf));
    if (busy) busyCycles++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    int waited;
    bit w;
    bit oc;
    bit r;
    rst    = 1'b1;
    wEn    = 1'b0;
    data   = 8'h00;
    ovfClr = 1'b0;

    // Reset state
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Single 0x55 frame: start low two cycles after the push, busy for one frame
    busyCycles = 0;
    step(1'b1, 8'h55, 1'b0, 1'b0);
    idle(50);
    chk("t1_busy_len", 32'(busyCycles), 32'(FRAME));

    // Two back-to-back frames with no idle gap
    step(1'b1, 8'hA3, 1'b0, 1'b0);
    step(1'b1, 8'h0F, 1'b0, 1'b0);
    idle(2 * FRAME + 10);

    // Nine consecutive pushes while idle: all accepted thanks to the early pop
    for (int i = 0; i < 9; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    chk("t3_no_overflow", 32'(overflow), 32'(0));
    idle(9 * FRAME + 5);

    // Fill while mid-frame, drop one, set-wins-over-clear, then clear
    step(1'b1, 8'($urandom), 1'b0, 1'b0);
    idle(3);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    chk("t4_full", 32'(full), 32'(1));
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    chk("t4_ovf_set", 32'(overflow), 32'(1));
    step(1'b1, 8'hFF, 1'b1, 1'b0);
    chk("t4_ovf_set_wins", 32'(overflow), 32'(1));
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t4_ovf_clr", 32'(overflow), 32'(0));

    // Keep pushing while full: pushes coinciding with a pop are taken across pointer wrap
    for (int i = 0; i < 3 * FRAME; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    idle(9 * FRAME + 5);

    // Random traffic with occasional clears and resets
    for (int i = 0; i < 2000; i++) begin
      w  = ($urandom_range(0, 99) < 30);
      oc = ($urandom_range(0, 99) < 3);
      r  = ($urandom_range(0, 999) < 2);
      step(w, 8'($urandom), oc, r);
    end
    idle(9 * FRAME + 5);

    // Reset during data bit 3 aborts the frame and discards the queued byte
    step(1'b1, 8'($urandom), 1'b0, 1'b0);
    step(1'b1, 8'($urandom), 1'b0, 1'b0);
    waited = 0;
    while (!(mInFrame && mPos == 4 * CPB + 1) && waited < 200) begin
      idle(1);
      waited++;
    end
    chk("t6_reach_bit3", 32'(waited < 200), 32'(1));
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t6_tx_high", 32'(tx), 32'(1));
    chk("t6_empty", 32'(empty), 32'(1));
    busyCycles = 0;
    idle(2 * FRAME);
    chk("t6_no_frame", 32'(busyCycles), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
